// File: rtl/bp_cce_pkg.sv
// Shared types for the CCE invalidation sequencer.
package bp_cce_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitAck,
    StDone
  } bp_cce_inv_seq_state_e;

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down counter with synchronous clear; simultaneous up and down cancel out.
module bsg_counter_up_down #(
  parameter int unsigned width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (up_i && !down_i) begin
      count_d = count_q + width_p'(1);
    end else if (down_i && !up_i) begin
      count_d = count_q - width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_cce_inv_sequencer.sv
// Walks a directory sharers vector, issuing one invalidate per sharer (lowest index first),
// then waits for every invalidate ack before reporting completion.
module bp_cce_inv_sequencer #(
  parameter  int unsigned num_lce_p          = 8,
  parameter  int unsigned lce_assoc_p        = 8,
  parameter  int unsigned paddr_width_p      = 40,
  localparam int unsigned lce_id_width_lp    = $clog2(num_lce_p),
  localparam int unsigned lce_assoc_width_lp = $clog2(lce_assoc_p),
  localparam int unsigned cnt_width_lp       = $clog2(num_lce_p + 1)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      start_v_i,
  output logic                                      start_ready_o,
  input  logic [paddr_width_p-1:0]                  addr_i,
  input  logic [lce_id_width_lp-1:0]                req_lce_i,
  input  logic                                      exclude_req_i,
  input  logic [num_lce_p-1:0]                      sharers_hits_i,
  input  logic [num_lce_p*lce_assoc_width_lp-1:0]   sharers_ways_i,
  output logic                                      cmd_v_o,
  input  logic                                      cmd_ready_i,
  output logic [lce_id_width_lp-1:0]                cmd_lce_o,
  output logic [lce_assoc_width_lp-1:0]             cmd_way_o,
  output logic [paddr_width_p-1:0]                  cmd_addr_o,
  input  logic                                      ack_v_i,
  output logic                                      busy_o,
  output logic                                      done_v_o,
  input  logic                                      done_yumi_i,
  output logic [cnt_width_lp-1:0]                   inv_count_o
);

  import bp_cce_pkg::*;

  bp_cce_inv_seq_state_e state_q;

  logic [num_lce_p-1:0]                    mask_q, start_mask, sel_onehot, mask_rest;
  logic [num_lce_p*lce_assoc_width_lp-1:0] ways_q;
  logic [paddr_width_p-1:0]                addr_q;
  logic [cnt_width_lp-1:0]                 count_q, pending;
  logic [lce_id_width_lp-1:0]              sel_idx;
  logic                                    send_hs, ack_dec, start_hs, pending_drains;

  always_comb begin
    start_mask = sharers_hits_i;
    if (exclude_req_i) start_mask[req_lce_i] = 1'b0;
  end

  // Priority encode: lowest set bit of the remaining mask wins.
  always_comb begin
    sel_idx = '0;
    for (int i = num_lce_p - 1; i >= 0; i--) begin
      if (mask_q[i]) sel_idx = lce_id_width_lp'(i);
    end
  end

  assign sel_onehot = num_lce_p'(1) << sel_idx;
  assign mask_rest  = mask_q & ~sel_onehot;

  assign start_ready_o = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign cmd_v_o       = (state_q == StSend);
  assign done_v_o      = (state_q == StDone);
  assign cmd_lce_o     = sel_idx;
  assign cmd_way_o     = ways_q[sel_idx * lce_assoc_width_lp +: lce_assoc_width_lp];
  assign cmd_addr_o    = addr_q;
  assign inv_count_o   = count_q;

  assign start_hs = start_v_i & start_ready_o;
  assign send_hs  = cmd_v_o & cmd_ready_i;
  assign ack_dec  = ack_v_i & (pending != '0) & busy_o;

  // No sends happen in WAIT_ACK, so only an ack can move pending.
  assign pending_drains = (pending == '0) || ((pending == cnt_width_lp'(1)) && ack_dec);

  bsg_counter_up_down #(
    .width_p(cnt_width_lp)
  ) u_pending (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(start_hs),
    .up_i   (send_hs),
    .down_i (ack_dec),
    .count_o(pending)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      mask_q  <= '0;
      ways_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_v_i) begin
            mask_q  <= start_mask;
            ways_q  <= sharers_ways_i;
            addr_q  <= addr_i;
            count_q <= '0;
            state_q <= (start_mask == '0) ? StDone : StSend;
          end
        end
        StSend: begin
          if (cmd_ready_i) begin
            mask_q  <= mask_rest;
            count_q <= count_q + cnt_width_lp'(1);
            if (mask_rest == '0) state_q <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (pending_drains) state_q <= StDone;
        end
        StDone: begin
          if (done_yumi_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(ack_v_i && (pending == '0)))
        else $warning("bp_cce_inv_sequencer: ack_v_i with no outstanding invalidate ignored");
      assert (!(start_v_i && !start_ready_o))
        else $error("bp_cce_inv_sequencer: start_v_i raised while busy");
    end
  end

endmodule

// File: tb/tb_bp_cce_inv_sequencer.sv
// Directed bench for bp_cce_inv_sequencer with a command scoreboard.
module tb_bp_cce_inv_sequencer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_v_i = 1'b0;
  logic        start_ready_o;
  logic [39:0] addr_i = '0;
  logic [2:0]  req_lce_i = '0;
  logic        exclude_req_i = 1'b0;
  logic [7:0]  sharers_hits_i = '0;
  logic [23:0] sharers_ways_i = '0;
  logic        cmd_v_o;
  logic        cmd_ready_i = 1'b0;
  logic [2:0]  cmd_lce_o;
  logic [2:0]  cmd_way_o;
  logic [39:0] cmd_addr_o;
  logic        ack_v_i = 1'b0;
  logic        busy_o;
  logic        done_v_o;
  logic        done_yumi_i = 1'b0;
  logic [3:0]  inv_count_o;

  typedef struct packed {
    logic [2:0]  lce;
    logic [2:0]  way;
    logic [39:0] addr;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bp_cce_inv_sequencer #(
    .num_lce_p    (8),
    .lce_assoc_p  (8),
    .paddr_width_p(40)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .start_v_i     (start_v_i),
    .start_ready_o (start_ready_o),
    .addr_i        (addr_i),
    .req_lce_i     (req_lce_i),
    .exclude_req_i (exclude_req_i),
    .sharers_hits_i(sharers_hits_i),
    .sharers_ways_i(sharers_ways_i),
    .cmd_v_o       (cmd_v_o),
    .cmd_ready_i   (cmd_ready_i),
    .cmd_lce_o     (cmd_lce_o),
    .cmd_way_o     (cmd_way_o),
    .cmd_addr_o    (cmd_addr_o),
    .ack_v_i       (ack_v_i),
    .busy_o        (busy_o),
    .done_v_o      (done_v_o),
    .done_yumi_i   (done_yumi_i),
    .inv_count_o   (inv_count_o)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Drives one start cycle and pushes the expected command stream to the scoreboard.
  task automatic start_op(input logic [7:0] hits, input logic [2:0] req, input logic excl,
                          input logic [23:0] ways, input logic [39:0] addr);
    logic [7:0] mask;
    logic [7:0] one;
    cmd_t       c;
    one  = 8'h01;
    mask = hits & ~(excl ? (one << req) : 8'h00);
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        c.lce  = 3'(i);
        c.way  = ways[3*i +: 3];
        c.addr = addr;
        exp_q.push_back(c);
      end
    end
    start_v_i      = 1'b1;
    sharers_hits_i = hits;
    req_lce_i      = req;
    exclude_req_i  = excl;
    sharers_ways_i = ways;
    addr_i         = addr;
    step();
    start_v_i      = 1'b0;
  endtask

  // Expects n back-to-back handshakes (cmd_ready_i must be high); optional ack on the last one.
  task automatic send_expected(input int n, input logic ack_on_last);
    cmd_t c;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
      end else begin
        c = exp_q.pop_front();
        chk("cmd_v", 64'(cmd_v_o), 64'd1);
        chk("cmd_lce", 64'(cmd_lce_o), 64'(c.lce));
        chk("cmd_way", 64'(cmd_way_o), 64'(c.way));
        chk("cmd_addr", 64'(cmd_addr_o), 64'(c.addr));
      end
      if (ack_on_last && (k == n - 1)) ack_v_i = 1'b1;
      step();
      ack_v_i = 1'b0;
    end
  endtask

  task automatic acks(input int n);
    ack_v_i = 1'b1;
    repeat (n) step();
    ack_v_i = 1'b0;
  endtask

  task automatic yumi();
    done_yumi_i = 1'b1;
    step();
    done_yumi_i = 1'b0;
  endtask

  initial begin
    step();
    step();
    reset_i = 1'b0;
    chk("rst_start_ready", 64'(start_ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_cmd_v", 64'(cmd_v_o), 64'd0);
    chk("rst_done_v", 64'(done_v_o), 64'd0);
    chk("rst_inv_count", 64'(inv_count_o), 64'd0);
    chk("rst_cmd_addr", 64'(cmd_addr_o), 64'd0);

    // Empty mask: requester is the only sharer.
    start_op(8'b0000_1000, 3'd3, 1'b1, 24'h123456, 40'h00_1000_0040);
    chk("empty_done_v", 64'(done_v_o), 64'd1);
    chk("empty_cmd_v", 64'(cmd_v_o), 64'd0);
    chk("empty_inv_count", 64'(inv_count_o), 64'd0);
    chk("empty_start_ready", 64'(start_ready_o), 64'd0);
    yumi();
    chk("empty_back_idle", 64'(start_ready_o), 64'd1);

    // Three sharers after excluding the requester.
    cmd_ready_i = 1'b1;
    start_op(8'b1010_0110, 3'd1, 1'b1, 24'hFAC688, 40'hAB_CDEF_0080);
    send_expected(3, 1'b0);
    chk("t2_wait_cmd_v", 64'(cmd_v_o), 64'd0);
    chk("t2_wait_busy", 64'(busy_o), 64'd1);
    chk("t2_wait_inv_count", 64'(inv_count_o), 64'd3);
    acks(2);
    chk("t2_two_acks_done", 64'(done_v_o), 64'd0);
    acks(1);
    chk("t2_done_v", 64'(done_v_o), 64'd1);
    chk("t2_inv_count", 64'(inv_count_o), 64'd3);
    yumi();

    // Backpressure: selection held stable while cmd_ready_i is low.
    cmd_ready_i = 1'b0;
    start_op(8'b0000_0011, 3'd0, 1'b0, 24'h00003D, 40'h12_3456_7800);
    for (int k = 0; k < 4; k++) begin
      chk("t3_stall_cmd_v", 64'(cmd_v_o), 64'd1);
      chk("t3_stall_cmd_lce", 64'(cmd_lce_o), 64'd0);
      step();
    end
    cmd_ready_i = 1'b1;
    send_expected(2, 1'b0);
    cmd_ready_i = 1'b0;
    acks(2);
    chk("t3_done_v", 64'(done_v_o), 64'd1);
    chk("t3_inv_count", 64'(inv_count_o), 64'd2);
    yumi();

    // Ack coincident with the last send keeps one ack outstanding.
    cmd_ready_i = 1'b1;
    start_op(8'b0000_0011, 3'd2, 1'b0, 24'h000015, 40'h00_0000_0100);
    send_expected(2, 1'b1);
    cmd_ready_i = 1'b0;
    chk("t4_after_last_done", 64'(done_v_o), 64'd0);
    chk("t4_after_last_cmd_v", 64'(cmd_v_o), 64'd0);
    step();
    chk("t4_still_waiting", 64'(done_v_o), 64'd0);
    acks(1);
    chk("t4_done_v", 64'(done_v_o), 64'd1);
    chk("t4_inv_count", 64'(inv_count_o), 64'd2);
    yumi();

    // Reset mid-SEND drops the operation and any outstanding acks.
    cmd_ready_i = 1'b1;
    start_op(8'b0000_1110, 3'd0, 1'b0, 24'h000FA8, 40'h55_0000_0200);
    send_expected(1, 1'b0);
    reset_i     = 1'b1;
    cmd_ready_i = 1'b0;
    step();
    chk("t5_rst_cmd_v", 64'(cmd_v_o), 64'd0);
    chk("t5_rst_start_ready", 64'(start_ready_o), 64'd1);
    chk("t5_rst_done_v", 64'(done_v_o), 64'd0);
    chk("t5_rst_inv_count", 64'(inv_count_o), 64'd0);
    reset_i = 1'b0;
    exp_q.delete();
    cmd_ready_i = 1'b1;
    start_op(8'b0000_0001, 3'd5, 1'b0, 24'h000006, 40'h66_0000_0300);
    send_expected(1, 1'b0);
    cmd_ready_i = 1'b0;
    acks(1);
    chk("t5_fresh_done_v", 64'(done_v_o), 64'd1);
    chk("t5_fresh_inv_count", 64'(inv_count_o), 64'd1);
    yumi();

    // Spurious acks are ignored; done is held until the engine consumes it.
    acks(1);
    chk("t6_idle_start_ready", 64'(start_ready_o), 64'd1);
    chk("t6_idle_busy", 64'(busy_o), 64'd0);
    start_op(8'b0000_0000, 3'd0, 1'b1, 24'h000000, 40'h77_0000_0400);
    acks(1);
    for (int k = 0; k < 5; k++) begin
      chk("t6_done_held", 64'(done_v_o), 64'd1);
      step();
    end
    yumi();
    chk("t6_released_done", 64'(done_v_o), 64'd0);
    chk("t6_released_ready", 64'(start_ready_o), 64'd1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
